remap_ppus: RTL and testbench

// - Post-processing unit array for the Remap instruction; sits directly downstream of the Remap input-prep stage.
// - Requantizes each 8-bit lane of the incoming X beat: Y = clamp(round(((X + neg_Xz) * m1) >> n1) + Yz, 0, 255).
// - Emits one Y beat per X beat, same width, to the Remap write-back stage; valid/last travel with the data.

---
 rtl/remap_ppus_pkg.sv | 10 +
 rtl/remap_ppus_if.sv | 23 ++
 rtl/remap_ppu.sv | 46 ++++
 rtl/remap_ppus.sv | 42 ++++
 tb/tb_remap_ppus.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/remap_ppus_pkg.sv
// remap_ppus_pkg: lane geometry (LANES = S*R), fixed latency and the output saturation helper
package remap_ppus_pkg;
  localparam int S = 2;
  localparam int R = 2;
  localparam int LANES = S * R;
  localparam int LAT = 4;
  function automatic logic [7:0] sat_u8(input logic signed [37:0] y);
    return (y < 38'sd0) ? 8'd0 : ((y > 38'sd255) ? 8'hff : y[7:0]);
  endfunction
endpackage

// File: rtl/remap_ppus_if.sv
// remap_ppus_if: X-beat input bus and Y-beat output bus of the requantizer array
interface remap_ppus_if;
  import remap_ppus_pkg::*;
  logic [LANES*8-1:0] ppus_Xs;
  logic               ppus_Xs_vld;
  logic               ppus_Xs_last;
  logic signed [8:0]  ppus_neg_Xz;
  logic [7:0]         ppus_Yz;
  logic [25:0]        ppus_m1;
  logic [5:0]         ppus_n1;
  logic [LANES*8-1:0] Ys;
  logic               Ys_vld;
  logic               Ys_last;
  logic               busy;
  modport master (
    output ppus_Xs, ppus_Xs_vld, ppus_Xs_last, ppus_neg_Xz, ppus_Yz, ppus_m1, ppus_n1,
    input  Ys, Ys_vld, Ys_last, busy
  );
  modport slave (
    input  ppus_Xs, ppus_Xs_vld, ppus_Xs_last, ppus_neg_Xz, ppus_Yz, ppus_m1, ppus_n1,
    output Ys, Ys_vld, Ys_last, busy
  );
endinterface

// File: rtl/remap_ppu.sv
// remap_ppu: one-lane 4-stage requantizer; REMAP_ROUND_EN selects round-half-up instead of floor at the shift
module remap_ppu
  import remap_ppus_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        x,
  input  logic signed [8:0] neg_xz,
  input  logic [25:0]       m1,
  input  logic [5:0]        n1,
  input  logic [7:0]        yz,
  output logic [7:0]        y
);
  logic signed [9:0]  d_d, d_q;
  logic signed [36:0] p_d, p_q, q_d, q_q;
  logic [7:0]         y_d, y_q;
  logic signed [64:0] r_w, s_w;
  // offset, multiply, round/shift, zero-point add with saturation; the 65-bit shift path absorbs 2^(n1-1) up to n1=63
  always_comb begin
    d_d = $signed({2'b0, x}) + $signed({neg_xz[8], neg_xz});
    p_d = $signed({{27{d_q[9]}}, d_q}) * $signed({11'b0, m1});
`ifdef REMAP_ROUND_EN
    r_w = $signed({{28{p_q[36]}}, p_q}) + ((n1 != 6'd0) ? (65'sd1 <<< (n1 - 6'd1)) : 65'sd0);
`else
    r_w = $signed({{28{p_q[36]}}, p_q});
`endif
    s_w = r_w >>> n1;
    q_d = s_w[36:0];
    y_d = sat_u8($signed({q_q[36], q_q}) + $signed({30'b0, yz}));
  end
  // data stages load every cycle; validity is tracked by the top
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_q <= '0;
      p_q <= '0;
      q_q <= '0;
      y_q <= '0;
    end else begin
      d_q <= d_d;
      p_q <= p_d;
      q_q <= q_d;
      y_q <= y_d;
    end
  end
  assign y = y_q;
endmodule

// File: rtl/remap_ppus.sv
// remap_ppus: LANES-wide requantizer array with shared vld/last/busy chain; REMAP_ROUND_EN enables rounding in each lane
module remap_ppus
  import remap_ppus_pkg::*;
(
  input logic         clk,
  input logic         rstn,
  remap_ppus_if.slave bus
);
  logic [LAT-1:0]     vld_d, vld_q, last_d, last_q;
  logic [LANES*8-1:0] ys_w;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    remap_ppu u_ppu (
      .clk    (clk),
      .rstn   (rstn),
      .x      (bus.ppus_Xs[i*8+:8]),
      .neg_xz (bus.ppus_neg_Xz),
      .m1     (bus.ppus_m1),
      .n1     (bus.ppus_n1),
      .yz     (bus.ppus_Yz),
      .y      (ys_w[i*8+:8])
    );
  end
  // last only travels when qualified by valid
  always_comb begin
    vld_d  = {vld_q[LAT-2:0], bus.ppus_Xs_vld};
    last_d = {last_q[LAT-2:0], bus.ppus_Xs_vld & bus.ppus_Xs_last};
  end
  // control shift chain aligned with the lane data stages
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end
  assign bus.Ys      = ys_w;
  assign bus.Ys_vld  = vld_q[LAT-1];
  assign bus.Ys_last = last_q[LAT-1];
  assign bus.busy    = |vld_q;
endmodule

// File: tb/tb_remap_ppus.sv
// tb_remap_ppus: directed and random beats against an arithmetic reference model with a latency queue
module tb_remap_ppus;
  import remap_ppus_pkg::*;
  localparam int W = LANES * 8;
`ifdef REMAP_ROUND_EN
  localparam logic [7:0] RND_A = 8'd1;
  localparam logic [7:0] RND_B = 8'd5;
`else
  localparam logic [7:0] RND_A = 8'd0;
  localparam logic [7:0] RND_B = 8'd4;
`endif
  typedef struct packed {
    logic         vld;
    logic         last;
    logic [W-1:0] y;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  exp_t pipe[$];
  int checks = 0;
  int failures = 0;
  remap_ppus_if bif ();
  remap_ppus dut (.clk(clk), .rstn(rstn), .bus(bif.slave));
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_y(input int x);
    longint p, q, y;
    p = longint'(x + int'(bif.ppus_neg_Xz)) * longint'(bif.ppus_m1);
`ifdef REMAP_ROUND_EN
    if (bif.ppus_n1 != 0) p = p + (longint'(1) << (int'(bif.ppus_n1) - 1));
`endif
    q = p >>> bif.ppus_n1;
    y = q + longint'(bif.ppus_Yz);
    return (y < 0) ? 8'd0 : ((y > 255) ? 8'd255 : 8'(y));
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*8+:8] = ref_y(int'(x[i*8+:8]));
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_x();
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*8+:8] = 8'($urandom);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic cfg(input int nxz, input int yz, input int m1, input int n1);
    bif.ppus_neg_Xz = 9'(nxz);
    bif.ppus_Yz     = 8'(yz);
    bif.ppus_m1     = 26'(m1);
    bif.ppus_n1     = 6'(n1);
  endtask

  task automatic cyc(input logic vld, input logic last, input logic [W-1:0] x, input logic [W-1:0] want);
    exp_t e, o;
    logic bexp;
    bif.ppus_Xs = x;
    bif.ppus_Xs_vld = vld;
    bif.ppus_Xs_last = last;
    e.vld = vld;
    e.last = vld & last;
    e.y = want;
    pipe.push_back(e);
    @(posedge clk);
    #1;
    o = '0;
    if (pipe.size() == LAT) o = pipe.pop_front();
    bexp = o.vld;
    foreach (pipe[k]) bexp |= pipe[k].vld;
    chk("ys_vld", W'(bif.Ys_vld), W'(o.vld));
    chk("ys_last", W'(bif.Ys_last), W'(o.last));
    chk("busy", W'(bif.busy), W'(bexp));
    if (o.vld) chk("ys", bif.Ys, o.y);
  endtask

  task automatic beat(input logic [W-1:0] x, input logic last);
    cyc(1'b1, last, x, ref_beat(x));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'($urandom), rnd_x(), '0);
  endtask

  task automatic reset_chk();
    chk("rst_ys", bif.Ys, '0);
    chk("rst_vld", W'(bif.Ys_vld), '0);
    chk("rst_last", W'(bif.Ys_last), '0);
    chk("rst_busy", W'(bif.busy), '0);
  endtask

  initial begin
    logic [W-1:0] lx;
    int nb;
    bif.ppus_Xs = '0;
    bif.ppus_Xs_vld = 1'b0;
    bif.ppus_Xs_last = 1'b0;
    cfg(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_chk();
    rstn = 1'b1;
    cfg(-50, 10, 1 << 20, 21);
    cyc(1'b1, 1'b1, {LANES{8'd100}}, {LANES{8'd35}});
    idle(4);
    cfg(0, 0, 1 << 20, 21);
    cyc(1'b1, 1'b1, {LANES{8'd1}}, {LANES{RND_A}});
    idle(4);
    cfg(-1, 5, 1 << 20, 21);
    cyc(1'b1, 1'b1, {LANES{8'd0}}, {LANES{RND_B}});
    idle(4);
    cfg(0, 0, 1 << 25, 20);
    cyc(1'b1, 1'b1, {LANES{8'd255}}, {LANES{8'd255}});
    idle(4);
    cfg(-256, 10, 1 << 25, 25);
    cyc(1'b1, 1'b1, {LANES{8'd0}}, {LANES{8'd0}});
    idle(4);
    for (int i = 0; i < LANES; i++) lx[i*8+:8] = 8'(i);
    cfg(0, 0, 1, 0);
    cyc(1'b1, 1'b1, lx, lx);
    idle(4);
    cfg(-7, 3, 12345, 10);
    for (int k = 0; k < 8; k++) begin
      beat(rnd_x(), k == 7);
      idle(k % 3);
    end
    idle(5);
    repeat (25) begin
      cfg(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 255)),
          int'($urandom & 32'h3ffffff),
          ($urandom % 2 == 0) ? int'($urandom_range(14, 30)) : int'($urandom_range(0, 63)));
      nb = int'($urandom_range(1, 10));
      for (int k = 0; k < nb; k++) begin
        beat(rnd_x(), (k == nb - 1) || ($urandom % 5 == 0));
        if ($urandom % 3 == 0) idle(1);
      end
      idle(4);
    end
    cfg(-50, 10, 1 << 20, 21);
    beat({LANES{8'd100}}, 1'b0);
    beat({LANES{8'd100}}, 1'b0);
    bif.ppus_Xs_vld = 1'b1;
    bif.ppus_Xs_last = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    reset_chk();
    pipe.delete();
    bif.ppus_Xs_vld = 1'b0;
    bif.ppus_Xs_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_chk();
    rstn = 1'b1;
    idle(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
